wave_channel: RTL and testbench

WAVE_CHANNEL -- requirements
Module: wave_channel

---
 rtl/wave_channel.sv | 92 +++++++++
 tb/tb_wave_channel.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wave_channel.sv
// wave_channel: sequenced waveform channel with period timer, linear and length gating
// Ports: clk/rst_l (async active-low); cpu/quarter/half_clk_en rate enables;
//        addr/data_in/we register writes at BASE_ADDR..BASE_ADDR+3; disable_l silences and clears length;
//        length_non_zero and out (OUT_WIDTH-bit sample) outputs.
// Option: WAVE_CHANNEL_ULTRASONIC_MUTE_EN freezes the phase while period < 2.
module wave_channel #(
  parameter logic [15:0] BASE_ADDR   = 16'h4008,
  parameter int          OUT_WIDTH   = 4,
  parameter int          TIMER_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 cpu_clk_en,
  input  logic                 quarter_clk_en,
  input  logic                 half_clk_en,
  input  logic [15:0]          addr,
  input  logic [7:0]           data_in,
  input  logic                 we,
  input  logic                 disable_l,
  output logic                 length_non_zero,
  output logic [OUT_WIDTH-1:0] out
);
  localparam logic [7:0] LEN_LUT [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
    8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30};
  logic                   r_control;
  logic [6:0]             r_reload_val;
  logic [1:0]             r_mode;
  logic [TIMER_WIDTH-1:0] r_period;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   r_reload_flag;
  logic [6:0]             r_linear;
  logic [7:0]             r_length;
  logic [OUT_WIDTH:0]     r_phase;
  logic                   w_wr0, w_wr1, w_wr2, w_wr3;
  logic                   w_tick, w_mute, w_adv;
  logic [OUT_WIDTH-1:0]   w_lo, w_hi;
  assign w_wr0  = we && cpu_clk_en && addr == BASE_ADDR;
  assign w_wr1  = we && cpu_clk_en && addr == BASE_ADDR + 16'd1;
  assign w_wr2  = we && cpu_clk_en && addr == BASE_ADDR + 16'd2;
  assign w_wr3  = we && cpu_clk_en && addr == BASE_ADDR + 16'd3;
  assign w_tick = cpu_clk_en && r_timer == '0;
`ifdef WAVE_CHANNEL_ULTRASONIC_MUTE_EN
  assign w_mute = r_period < TIMER_WIDTH'(2);
`else
  assign w_mute = 1'b0;
`endif
  assign w_adv  = w_tick && r_linear != '0 && r_length != '0 && !w_mute;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_control     <= 1'b0;
      r_reload_val  <= '0;
      r_mode        <= '0;
      r_period      <= '0;
      r_timer       <= '0;
      r_reload_flag <= 1'b0;
      r_linear      <= '0;
      r_length      <= '0;
      r_phase       <= '0;
    end else begin
      if (w_wr0) begin
        r_control    <= data_in[7];
        r_reload_val <= data_in[6:0];
      end
      if (w_wr1) r_mode <= data_in[1:0];
      if (w_wr2) r_period[7:0] <= data_in;
      // upper period bits come from the low bits of data_in; the rest of the byte is the length index
      if (w_wr3) r_period <= TIMER_WIDTH'({data_in, r_period[7:0]});
      if (cpu_clk_en) r_timer <= w_tick ? r_period : r_timer - TIMER_WIDTH'(1);
      if (quarter_clk_en) begin
        r_linear <= r_reload_flag ? r_reload_val : r_linear != '0 ? r_linear - 7'd1 : r_linear;
        if (!r_control) r_reload_flag <= 1'b0;
      end
      // placed after the quarter update so a same-cycle Reg3 write keeps the flag set
      if (w_wr3) r_reload_flag <= 1'b1;
      r_length <= !disable_l ? '0 :
                  w_wr3 ? LEN_LUT[data_in[7:3]] :
                  (half_clk_en && !r_control && r_length != '0) ? r_length - 8'd1 : r_length;
      if (w_adv) r_phase <= r_phase + 1'b1;
    end
  end
  assign w_lo = r_phase[OUT_WIDTH-1:0];
  assign w_hi = r_phase[OUT_WIDTH:1];
  always_comb begin
    out = r_mode == 2'd0 ? (r_phase[OUT_WIDTH] ? w_lo : ~w_lo) :
          r_mode == 2'd1 ? w_hi :
          r_mode == 2'd2 ? ~w_hi : {OUT_WIDTH{~r_phase[OUT_WIDTH]}};
  end
  assign length_non_zero = r_length != '0;
endmodule

// File: tb/tb_wave_channel.sv
// tb_wave_channel: scoreboard bench for wave_channel (step queue on out changes, snapshot queue for out/length)
module tb_wave_channel;
  logic clk = 0, rst_l = 0, cpu_clk_en = 0, quarter_clk_en = 0, half_clk_en = 0, we = 0, disable_l = 1;
  logic [15:0] addr = 0;
  logic [7:0]  data_in = 0;
  logic        length_non_zero;
  logic [3:0]  out;
  wave_channel dut (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en), .quarter_clk_en(quarter_clk_en),
    .half_clk_en(half_clk_en), .addr(addr), .data_in(data_in), .we(we), .disable_l(disable_l),
    .length_non_zero(length_non_zero), .out(out));
  always #5 clk = ~clk;
  typedef struct { string name; logic [3:0] o; logic l; } snap_t;
  typedef struct { logic [3:0] o; int gap; } step_t;
  snap_t q_snap[$];
  step_t q_step[$];
  snap_t sn;
  step_t st;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_cyc = 0;
  logic [3:0] last_out = 0;
  logic fin = 0;
`ifdef WAVE_CHANNEL_ULTRASONIC_MUTE_EN
  localparam logic [3:0] O1 = 4'd15, O2 = 4'd15;
`else
  localparam logic [3:0] O1 = 4'd14, O2 = 4'd13;
`endif
  always @(negedge clk) begin
    cyc++;
    if (!rst_l) last_out = out;
    else if (out !== last_out) begin
      n_cmp++;
      if (q_step.size() == 0) begin
        n_bad++;
        $display("FAIL step: out changed to %0d from %0d, required no change", out, last_out);
      end else begin
        st = q_step.pop_front();
        if (out !== st.o || (st.gap != 0 && cyc - last_cyc != st.gap)) begin
          n_bad++;
          $display("FAIL step: out=%0d after %0d cycles, required %0d after %0d", out, cyc - last_cyc, st.o, st.gap);
        end
      end
      last_cyc = cyc;
      last_out = out;
    end
    while (q_snap.size() != 0) begin
      sn = q_snap.pop_front();
      n_cmp++;
      if (out !== sn.o || length_non_zero !== sn.l) begin
        n_bad++;
        $display("FAIL %s: out=%0d length_non_zero=%0b, required out=%0d length_non_zero=%0b",
                 sn.name, out, length_non_zero, sn.o, sn.l);
      end
    end
    if (fin && q_step.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL step: %0d expected out changes not seen, required 0", q_step.size());
      q_step.delete();
    end
  end
  task automatic snap(input string n, input logic [3:0] o, input logic l);
    q_snap.push_back('{n, o, l});
  endtask
  task automatic step(input logic [3:0] o, input int g);
    q_step.push_back('{o, g});
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    data_in = d;
    we = 1;
    cycles(1);
    we = 0;
  endtask
  task automatic wait_steps(input int keep);
    int n = 0;
    while (q_step.size() > keep && n < 600) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask
  initial begin
    cycles(3);
    rst_l = 1;
    cpu_clk_en = 1;
    snap("reset", 15, 0);
    cycles(1000);
    snap("idle_1000", 15, 0);
    cpu_clk_en = 0;
    wr(16'h400B, 8'h08);
    cpu_clk_en = 1;
    wr(16'h400C, 8'h08);
    wr(16'h4007, 8'h08);
    snap("ignored_writes", 15, 0);
    wr(16'h4008, 8'h81);
    wr(16'h400A, 8'h02);
    wr(16'h400B, 8'h08);
    snap("len_load", 15, 1);
    for (int k = 1; k < 16; k++) step(4'(15 - k), k == 1 ? 0 : 3);
    for (int k = 17; k < 32; k++) step(4'(k - 16), k == 17 ? 6 : 3);
    step(14, 6); step(13, 3); step(12, 3); step(11, 3); step(10, 3);
    quarter_clk_en = 1;
    cycles(1);
    quarter_clk_en = 0;
    wait_steps(0);
    step(2, 2);
    step(3, 1);
    wr(16'h4009, 8'h01);
    snap("mode_saw", 2, 1);
    wait_steps(0);
    addr = 16'h400B;
    data_in = 8'h18;
    we = 1;
    rst_l = 0;
    cycles(3);
    we = 0;
    cycles(1);
    rst_l = 1;
    snap("reset_mid", 15, 0);
    cycles(5);
    snap("reset_hold", 15, 0);
    wr(16'h4008, 8'h00);
    wr(16'h400B, 8'h08);
    addr = 16'h400B;
    data_in = 8'h18;
    we = 1;
    quarter_clk_en = 1;
    half_clk_en = 1;
    cycles(1);
    we = 0;
    quarter_clk_en = 0;
    half_clk_en = 0;
    wr(16'h4008, 8'h01);
    quarter_clk_en = 1;
    cycles(1);
    quarter_clk_en = 0;
`ifndef WAVE_CHANNEL_ULTRASONIC_MUTE_EN
    step(14, 0);
    step(13, 1);
`endif
    half_clk_en = 1;
    cycles(1);
    snap("len_dec1", O1, 1);
    cycles(1);
    half_clk_en = 0;
    snap("len_zero", O2, 0);
    cycles(20);
    snap("frozen", O2, 0);
    addr = 16'h400B;
    data_in = 8'h18;
    we = 1;
    quarter_clk_en = 1;
    cycles(1);
    we = 0;
    quarter_clk_en = 0;
    snap("len_reload", O2, 1);
    disable_l = 0;
    wr(16'h400B, 8'h08);
    snap("disable_load", O2, 0);
    cycles(2);
    disable_l = 1;
    snap("disable_held", O2, 0);
    wr(16'h4008, 8'h81);
    wr(16'h400A, 8'h01);
    wr(16'h400B, 8'h08);
    quarter_clk_en = 1;
    cycles(1);
    quarter_clk_en = 0;
`ifdef WAVE_CHANNEL_ULTRASONIC_MUTE_EN
    cycles(20);
    snap("mute_frozen", O2, 1);
    disable_l = 0;
    cycles(2);
    disable_l = 1;
    snap("final", O2, 0);
`else
    step(12, 0); step(11, 2); step(10, 2); step(9, 2); step(8, 2);
    wait_steps(1);
    disable_l = 0;
    cycles(3);
    disable_l = 1;
    snap("final", 8, 0);
`endif
    for (int n = 0; n < 100 && (q_step.size() != 0 || q_snap.size() != 0); n++) cycles(1);
    fin = 1;
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
